// File: rtl/axis_frame_ctrl.sv
// Cuts a continuous AXI-Stream into fixed-length packets (tlast on beat len), armed by start, ended by count or stop.
// Latency: 1 cycle input->output through a single registered stage; 1 beat/cycle when downstream is ready.
// Backpressure: s_axis_tready drops when the output register is full and m_axis_tready is low, and outside RUN.
//
// Ports: aclk/aresetn (async active-low); start/stop control pulses with cfg_len/cfg_num_pkts sampled on start;
//        busy/done/pkt_count status; s_axis_* input stream; m_axis_* registered output stream.
// Optional macro AXIS_FRAME_SOF_EN adds m_axis_tuser (start-of-packet flag) registered with the data.
module axis_frame_ctrl #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16,
  parameter int CNT_W  = 32
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                start,
  input  logic                stop,
  input  logic [LEN_W-1:0]    cfg_len,
  input  logic [CNT_W-1:0]    cfg_num_pkts,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    pkt_count,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic [DATA_W/8-1:0] m_axis_tkeep,
  output logic                m_axis_tlast,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready
`ifdef AXIS_FRAME_SOF_EN
  ,
  output logic                m_axis_tuser
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] beat_cnt;
  logic [CNT_W-1:0] npk_q;
  logic [CNT_W-1:0] in_pkts;    // packets whose last beat has entered the output register
  logic             stop_pend;  // stop seen mid-packet, finish this packet then drain

  logic             accept;
  logic             beat_last;
  logic             out_last;
  logic             final_pkt;
  logic [CNT_W-1:0] in_pkts_nxt;

  assign s_axis_tready = (state == RUN) && (!m_axis_tvalid || m_axis_tready);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign beat_last     = (beat_cnt == len_q - LEN_W'(1));
  assign out_last      = m_axis_tvalid && m_axis_tready && m_axis_tlast;
  assign in_pkts_nxt   = in_pkts + CNT_W'(1);
  // npk_q == 0 means unlimited, so the input-side count never ends the run
  assign final_pkt     = (npk_q != '0) && (in_pkts_nxt == npk_q);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= IDLE;
      len_q         <= LEN_W'(1);
      beat_cnt      <= '0;
      npk_q         <= '0;
      in_pkts       <= '0;
      stop_pend     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pkt_count     <= '0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
`ifdef AXIS_FRAME_SOF_EN
      m_axis_tuser  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;

      if (out_last && (pkt_count != '1)) begin
        pkt_count <= pkt_count + CNT_W'(1);
      end

      // Output register: load on input acceptance, empty when drained without a refill
      if (accept) begin
        m_axis_tdata  <= s_axis_tdata;
        m_axis_tkeep  <= '1;
        m_axis_tlast  <= beat_last;
        m_axis_tvalid <= 1'b1;
`ifdef AXIS_FRAME_SOF_EN
        m_axis_tuser  <= (beat_cnt == '0);
`endif
      end else if (m_axis_tready) begin
        m_axis_tkeep  <= '0;
        m_axis_tlast  <= 1'b0;
        m_axis_tvalid <= 1'b0;
`ifdef AXIS_FRAME_SOF_EN
        m_axis_tuser  <= 1'b0;
`endif
      end

      if (accept) begin
        beat_cnt <= beat_last ? '0 : beat_cnt + LEN_W'(1);
      end

      case (state)
        IDLE: begin
          if (start) begin
            len_q     <= (cfg_len == '0) ? LEN_W'(1) : cfg_len;
            npk_q     <= cfg_num_pkts;
            pkt_count <= '0;
            in_pkts   <= '0;
            beat_cnt  <= '0;
            stop_pend <= 1'b0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (accept && beat_last) begin
            in_pkts <= in_pkts_nxt;
            if (final_pkt || stop_pend || stop) begin
              stop_pend <= 1'b0;
              state     <= DRAIN;
            end
          end else if (stop) begin
            // A beat accepted at count 0 opens a new packet, which must still complete
            if ((beat_cnt == '0) && !accept) begin
              state <= DRAIN;
            end else begin
              stop_pend <= 1'b1;
            end
          end
        end
        DRAIN: begin
          // Only the final tlast beat can still be in the output register here
          if (!m_axis_tvalid || out_last) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_frame_ctrl.sv
`timescale 1ns/1ps
module tb_axis_frame_ctrl;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 16;
  localparam int CNT_W  = 32;
  localparam int KW     = DATA_W / 8;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b1;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [LEN_W-1:0]  cfg_len = '0;
  logic [CNT_W-1:0]  cfg_num_pkts = '0;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  pkt_count;
  logic [DATA_W-1:0] s_axis_tdata = 32'd1;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tready;
  logic [DATA_W-1:0] m_axis_tdata;
  logic [KW-1:0]     m_axis_tkeep;
  logic              m_axis_tlast;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b1;
`ifdef AXIS_FRAME_SOF_EN
  logic              m_axis_tuser;
`endif

  always #5 aclk = ~aclk;

  axis_frame_ctrl #(.DATA_W(DATA_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .stop(stop),
    .cfg_len(cfg_len), .cfg_num_pkts(cfg_num_pkts),
    .busy(busy), .done(done), .pkt_count(pkt_count),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready)
`ifdef AXIS_FRAME_SOF_EN
    , .m_axis_tuser(m_axis_tuser)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [DATA_W-1:0] dat;
    logic              last;
    logic              user;
  } beat_t;

  beat_t             exp_q[$];
  logic [DATA_W-1:0] last_q[$];
  int                user_idx_q[$];
  int                m_len = 1;
  longint            acc_cnt = 0;
  longint            limit = 0;     // total beats the run may accept; 0 = not yet bounded
  longint            pkt_model = 0;
  int                out_idx = 0;
  int                done_cnt = 0;
  bit                in_open = 0, run_active = 0, busy_exp = 0, done_due = 0;
  bit                hold_vld = 0;
  logic [DATA_W-1:0] hold_dat;
  logic              hold_last;

  always @(negedge aclk) begin : model
    beat_t  b;
    longint lim2;
    logic   got_last;
    if (!aresetn) begin
      exp_q.delete();
      in_open = 0; run_active = 0; busy_exp = 0; done_due = 0; hold_vld = 0;
      pkt_model = 0; acc_cnt = 0; limit = 0;
    end else begin
      chk("busy", busy, busy_exp);
      chk("done", done, done_due);
      chk("pkt_count", pkt_count, pkt_model);
      chk("s_tready", s_axis_tready, in_open && (!m_axis_tvalid || m_axis_tready));
      if (done) done_cnt++;
      if (m_axis_tvalid) chk("tkeep", m_axis_tkeep, {KW{1'b1}});
      if (hold_vld) begin
        chk("hold_vld", m_axis_tvalid, 1'b1);
        chk("hold_dat", m_axis_tdata, hold_dat);
        chk("hold_last", m_axis_tlast, hold_last);
      end

      got_last = 1'b0;
      if (m_axis_tvalid && m_axis_tready) begin
        out_idx++;
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_beat: got data %0h, expected no beat (t=%0t)", m_axis_tdata, $time);
        end else begin
          b = exp_q.pop_front();
          chk("tdata", m_axis_tdata, b.dat);
          chk("tlast", m_axis_tlast, b.last);
`ifdef AXIS_FRAME_SOF_EN
          chk("tuser", m_axis_tuser, b.user);
          if (m_axis_tuser) user_idx_q.push_back(out_idx);
`endif
          got_last = b.last;
          if (b.last) begin
            last_q.push_back(m_axis_tdata);
            pkt_model++;
          end
        end
      end

      done_due = 0;
      if (got_last && run_active && limit != 0 && pkt_model * m_len == limit) begin
        done_due = 1; busy_exp = 0; run_active = 0;
      end

      if (s_axis_tvalid && s_axis_tready) begin
        if (!in_open) begin
          vectors++; miscompares++;
          $display("FAIL accept_closed: got accepted beat %0h, expected input closed (t=%0t)", s_axis_tdata, $time);
        end else begin
          b.dat  = s_axis_tdata;
          b.last = (acc_cnt % m_len) == (m_len - 1);
          b.user = (acc_cnt % m_len) == 0;
          exp_q.push_back(b);
          acc_cnt++;
          if (limit != 0 && acc_cnt >= limit) in_open = 0;
        end
      end

      // stop rounds the run up to the end of the packet in progress
      if (stop && run_active) begin
        lim2 = ((acc_cnt + m_len - 1) / m_len) * m_len;
        if (limit == 0 || lim2 < limit) limit = lim2;
        if (acc_cnt >= limit) in_open = 0;
      end

      if (start && !run_active) begin
        m_len      = (cfg_len == 0) ? 1 : int'(cfg_len);
        limit      = longint'(cfg_num_pkts) * m_len;
        acc_cnt    = 0;
        in_open    = 1;
        run_active = 1;
        busy_exp   = 1;
        pkt_model  = 0;
        out_idx    = 0;
      end

      hold_vld  = m_axis_tvalid && !m_axis_tready;
      hold_dat  = m_axis_tdata;
      hold_last = m_axis_tlast;
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_start(input int len, input longint npk, input bit with_stop);
    cfg_len = LEN_W'(len);
    cfg_num_pkts = CNT_W'(npk);
    start = 1'b1;
    stop = with_stop;
    @(posedge aclk); #1;
    start = 1'b0;
    stop = 1'b0;
  endtask

  // Runs until done (or max_acc input beats when max_acc > 0)
  task automatic drive(input int max_acc, input int stop_after, input bit rnd_vld,
                       input bit alt_rdy, input int budget);
    int acc_n = 0;
    int cyc = 0;
    bit seen = 0, stop_sent = 0, acc;
    while (!seen && cyc < budget && !(max_acc > 0 && acc_n >= max_acc)) begin
      s_axis_tvalid = rnd_vld ? 1'($urandom_range(0, 1)) : 1'b1;
      m_axis_tready = alt_rdy ? (cyc % 2 == 0) : 1'b1;
      stop = 1'b0;
      if (stop_after > 0 && !stop_sent && acc_n == stop_after) begin
        stop = 1'b1; stop_sent = 1;
      end
      @(negedge aclk);
      acc = s_axis_tvalid && s_axis_tready;
      if (done) seen = 1;
      @(posedge aclk); #1;
      if (acc) begin
        acc_n++;
        s_axis_tdata = s_axis_tdata + 1;
      end
      cyc++;
    end
    s_axis_tvalid = 1'b0;
    stop = 1'b0;
    m_axis_tready = 1'b1;
    if (max_acc == 0 && !seen) begin
      vectors++; miscompares++;
      $display("FAIL done_timeout: got no done in %0d cycles, expected done", budget);
    end
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int d0, dn, len, npk, sa;
    #2 aresetn = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_s_tready", s_axis_tready, 1'b0);
    chk("rst_m_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_m_tlast", m_axis_tlast, 1'b0);
    chk("rst_m_tdata", m_axis_tdata, 0);
    chk("rst_m_tkeep", m_axis_tkeep, 0);
    repeat (2) @(negedge aclk);
    #2 aresetn = 1'b1;
    @(posedge aclk); #1;

    // 1: len 4, 3 packets, data 1..12
    last_q.delete(); dn = done_cnt; s_axis_tdata = 32'd1;
    do_start(4, 3, 0);
    drive(0, 0, 0, 0, 100);
    chk("t1_nlast", last_q.size(), 3);
    if (last_q.size() == 3) begin
      chk("t1_last0", last_q[0], 4);
      chk("t1_last1", last_q[1], 8);
      chk("t1_last2", last_q[2], 12);
    end
    chk("t1_pkt_count", pkt_count, 3);
    chk("t1_busy", busy, 1'b0);
    chk("t1_s_tready", s_axis_tready, 1'b0);
    repeat (3) @(posedge aclk); #1;
    chk("t1_done_once", done_cnt - dn, 1);

    // 2: len 0 treated as 1; stop alongside start in IDLE must not block it
    last_q.delete(); dn = done_cnt; d0 = s_axis_tdata;
    do_start(0, 2, 1);
    drive(0, 0, 0, 0, 100);
    chk("t2_nlast", last_q.size(), 2);
    if (last_q.size() == 2) begin
      chk("t2_last0", last_q[0], d0);
      chk("t2_last1", last_q[1], d0 + 1);
    end
    chk("t2_done_once", done_cnt - dn, 1);
    stop = 1'b1; @(posedge aclk); #1; stop = 1'b0;
    repeat (2) @(posedge aclk); #1;
    chk("idle_stop_busy", busy, 1'b0);

    // 3: unlimited, stop after 7 beats -> packet of 5 completes
    last_q.delete(); s_axis_tdata = 32'd1;
    do_start(5, 0, 0);
    drive(0, 7, 0, 0, 100);
    chk("t3_nlast", last_q.size(), 2);
    if (last_q.size() == 2) begin
      chk("t3_last0", last_q[0], 5);
      chk("t3_last1", last_q[1], 10);
    end
    chk("t3_pkt_count", pkt_count, 2);

    // 4: len 3, ready toggling, random valid
    last_q.delete(); d0 = s_axis_tdata;
    do_start(3, 5, 0);
    drive(0, 0, 1, 1, 400);
    chk("t4_nlast", last_q.size(), 5);
    foreach (last_q[i]) chk("t4_last", last_q[i], d0 + 3 * i + 2);

    // 5: reset during beat 2 of 4, then restart
    do_start(4, 0, 0);
    drive(2, 0, 0, 0, 50);
    aresetn = 1'b0;
    #1;
    chk("t5_busy", busy, 1'b0);
    chk("t5_m_tvalid", m_axis_tvalid, 1'b0);
    chk("t5_m_tlast", m_axis_tlast, 1'b0);
    chk("t5_m_tdata", m_axis_tdata, 0);
    chk("t5_m_tkeep", m_axis_tkeep, 0);
    chk("t5_s_tready", s_axis_tready, 1'b0);
    chk("t5_pkt_count", pkt_count, 0);
    @(negedge aclk); #2 aresetn = 1'b1;
    @(posedge aclk); #1;
    last_q.delete(); d0 = s_axis_tdata;
    do_start(4, 1, 0);
    drive(0, 0, 0, 0, 100);
    chk("t5_nlast", last_q.size(), 1);
    if (last_q.size() == 1) chk("t5_last0", last_q[0], d0 + 3);

`ifdef AXIS_FRAME_SOF_EN
    // 6: start-of-packet flag
    user_idx_q.delete();
    do_start(3, 2, 0);
    drive(0, 0, 0, 0, 100);
    chk("t6_nuser", user_idx_q.size(), 2);
    if (user_idx_q.size() == 2) begin
      chk("t6_user0", user_idx_q[0], 1);
      chk("t6_user1", user_idx_q[1], 4);
    end
`endif

    // random runs: bounded by count, or unlimited ended by a mid-packet stop
    for (int r = 0; r < 8; r++) begin
      if (r % 3 == 0) begin
        len = $urandom_range(2, 6);
        npk = 0;
        sa  = $urandom_range(1, 3) * len + $urandom_range(1, len - 1);
      end else begin
        len = $urandom_range(1, 6);
        npk = $urandom_range(1, 4);
        sa  = 0;
      end
      dn = done_cnt;
      do_start(len, npk, 0);
      drive(0, sa, 1, r[0], 600);
      chk("rnd_done_once", done_cnt - dn, 1);
      chk("rnd_queue_empty", exp_q.size(), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
